// File: rtl/ir_pulse_encoder_pkg.sv
// Shared types and constants for the IR pulse-width link (package ir_pkg).
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    DONE  = 2'd3
  } ir_tx_state_t;

  localparam int unsigned IR_ONE_HIGH_DEF  = 15;
  localparam int unsigned IR_ZERO_HIGH_DEF = 5;
  localparam int unsigned IR_GAP_LOW_DEF   = 4;

  // Mark-length windows the receiver classifies as 1 and 0
  localparam int unsigned IR_ONE_MIN  = 13;
  localparam int unsigned IR_ONE_MAX  = 18;
  localparam int unsigned IR_ZERO_MIN = 1;
  localparam int unsigned IR_ZERO_MAX = 9;

  function automatic int unsigned ir_max3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ir_pulse_encoder_timer.sv
// Loadable down-counter timing marks and spaces; expire flags the last cycle of a period.
module ir_pulse_timer
  import ir_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         readReset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         expire
);

  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  // A period loaded with N runs N cycles: value walks N..1, expiring at 1
  assign expire = (value == W'(1));

endmodule

// File: rtl/ir_pulse_encoder.sv
// IR pulse-width transmitter: serialises a word MSB first as long/short marks with fixed spaces.
// Optional build macro IR_CARRIER_EN gates marks with a square-wave carrier.
module ir_pulse_encoder
  import ir_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ONE_HIGH     = IR_ONE_HIGH_DEF,
  parameter int unsigned ZERO_HIGH    = IR_ZERO_HIGH_DEF,
  parameter int unsigned GAP_LOW      = IR_GAP_LOW_DEF,
  parameter int unsigned CARRIER_HALF = 2
) (
  input  logic              clk,
  input  logic              readReset,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  input  logic              abort,
  output logic              ir_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TW = $clog2(ir_max3(ONE_HIGH, ZERO_HIGH, GAP_LOW) + 1);
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] ONE_T  = TW'(ONE_HIGH);
  localparam logic [TW-1:0] ZERO_T = TW'(ZERO_HIGH);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP_LOW);

  if (!(ONE_HIGH > ZERO_HIGH && ZERO_HIGH >= 1)) begin : g_chk_marks
    $error("ir_pulse_encoder: need ONE_HIGH > ZERO_HIGH >= 1");
  end
  if (GAP_LOW < 2) begin : g_chk_gap
    $error("ir_pulse_encoder: GAP_LOW must be at least 2");
  end
  if (ONE_HIGH < IR_ONE_MIN || ONE_HIGH > IR_ONE_MAX ||
      ZERO_HIGH < IR_ZERO_MIN || ZERO_HIGH > IR_ZERO_MAX) begin : g_chk_window
    $error("ir_pulse_encoder: mark lengths outside receiver windows");
  end
  if (DATA_W < 2) begin : g_chk_width
    $error("ir_pulse_encoder: DATA_W must be at least 2");
  end
  if (CARRIER_HALF < 1) begin : g_chk_carrier
    $error("ir_pulse_encoder: CARRIER_HALF must be at least 1");
  end

  ir_tx_state_t      state, state_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt;
  logic              accept, mark_end, advance;
  logic              tmr_load, tmr_dec, tmr_expire;
  logic [TW-1:0]     tmr_val, tmr_value;
  logic              envelope;

  ir_pulse_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .readReset (readReset),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .dec       (tmr_dec),
    .value     (tmr_value),
    .expire    (tmr_expire)
  );

  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    accept    = 1'b0;
    mark_end  = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (send_valid && !abort) begin
          accept    = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = send_data[DATA_W-1] ? ONE_T : ZERO_T;
          state_nxt = MARK;
        end
      end
      MARK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_expire) begin
          mark_end  = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = GAP_T;
          state_nxt = SPACE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SPACE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_expire) begin
          if (bit_cnt == '0) begin
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = shift_reg[DATA_W-1] ? ONE_T : ZERO_T;
            state_nxt = MARK;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The sent bit is shifted out when its mark ends, so during SPACE the
  // register MSB already holds the next bit to send.
  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (accept) begin
        shift_reg <= send_data;
        bit_cnt   <= BW'(DATA_W - 1);
      end else begin
        if (mark_end) begin
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        end
        if (advance) begin
          bit_cnt <= bit_cnt - 1'b1;
        end
      end
    end
  end

  assign send_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign envelope   = (state == MARK);

`ifdef IR_CARRIER_EN
  localparam int unsigned CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [CW-1:0] car_cnt;
  logic          car_lvl;
  logic          mark_entry;

  assign mark_entry = (state_nxt == MARK) && (state != MARK);

  // Phase restarts on every mark so each mark starts with the carrier high
  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      car_cnt <= '0;
      car_lvl <= 1'b1;
    end else if (mark_entry) begin
      car_cnt <= '0;
      car_lvl <= 1'b1;
    end else if (state == MARK) begin
      if (car_cnt == CW'(CARRIER_HALF - 1)) begin
        car_cnt <= '0;
        car_lvl <= ~car_lvl;
      end else begin
        car_cnt <= car_cnt + 1'b1;
      end
    end
  end

  assign ir_out = envelope & car_lvl;
`else
  assign ir_out = envelope;
`endif

endmodule

// File: tb/tb_ir_pulse_encoder.sv
// Scoreboard bench for ir_pulse_encoder: stimulus queues expected marks/frames, a monitor decodes the line.
module tb_ir_pulse_encoder;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ONE_HIGH  = 15;
  localparam int unsigned ZERO_HIGH = 5;
  localparam int unsigned GAP_LOW   = 4;

  typedef struct {
    logic [31:0] word;
    int unsigned len;
  } frame_t;

  logic        clk = 1'b0;
  logic        readReset;
  logic        send_valid;
  logic [31:0] send_data;
  logic        send_ready;
  logic        abort;
  logic        ir_out;
  logic        busy;
  logic        done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_marks[$];
  frame_t      exp_frames[$];

  ir_pulse_encoder #(
    .DATA_W       (DATA_W),
    .ONE_HIGH     (ONE_HIGH),
    .ZERO_HIGH    (ZERO_HIGH),
    .GAP_LOW      (GAP_LOW),
    .CARRIER_HALF (2)
  ) dut (
    .clk        (clk),
    .readReset  (readReset),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .abort      (abort),
    .ir_out     (ir_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: measures marks and spaces, decodes bits with the receiver windows.
  initial begin : monitor
    int unsigned hi_run, lo_run, frame_cyc, nbits, m;
    bit          in_space, rx_bit;
    logic [31:0] word_acc;
    frame_t      f;
    hi_run = 0; lo_run = 0; frame_cyc = 0; nbits = 0; in_space = 0; word_acc = '0;
    forever begin
      @(negedge clk);
      if (readReset || !busy) begin
        hi_run = 0; lo_run = 0; frame_cyc = 0; nbits = 0; in_space = 0; word_acc = '0;
      end else begin
        frame_cyc++;
        if (ir_out) begin
          if (in_space) begin
            check("space_len", lo_run, GAP_LOW);
            in_space = 0;
          end
          hi_run++;
        end else begin
          if (hi_run != 0) begin
            if (exp_marks.size() == 0) begin
              check("mark_unexpected", hi_run, 0);
            end else begin
              m = exp_marks.pop_front();
              check("mark_len", hi_run, m);
            end
            rx_bit   = (hi_run >= 13 && hi_run <= 18);
            word_acc = {word_acc[30:0], rx_bit};
            nbits++;
            hi_run   = 0;
            in_space = 1;
            lo_run   = 0;
          end
          if (in_space) lo_run++;
        end
        if (done) begin
          check("last_space_len", lo_run - 1, GAP_LOW);
          in_space = 0;
          if (exp_frames.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            f = exp_frames.pop_front();
            check("frame_len", frame_cyc, f.len);
            check("rx_word", word_acc, f.word);
            check("bit_count", nbits, DATA_W);
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input bit hold);
    int unsigned cyc, len;
    frame_t      f;
    send_data  = w;
    send_valid = 1'b1;
    cyc = 0;
    while (!send_ready && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!send_ready) begin
      check("accept_timeout", 0, 1);
      send_valid = 1'b0;
      return;
    end
    len = DATA_W * GAP_LOW + 1;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      exp_marks.push_back(w[i] ? ONE_HIGH : ZERO_HIGH);
      len += w[i] ? ONE_HIGH : ZERO_HIGH;
    end
    f.word = w;
    f.len  = len;
    exp_frames.push_back(f);
    @(posedge clk); #1;
    check("ready_drop", send_ready, 0);
    check("busy_rise", busy, 1);
    check("first_mark", ir_out, 1);
    if (!hold) send_valid = 1'b0;
    send_data = ~w;
  endtask

  task automatic wait_idle();
    int unsigned cyc;
    cyc = 0;
    while (busy && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("frame_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  // Advance from the first mark cycle to the first cycle of mark number mark_no.
  task automatic skip_to_mark(input int unsigned mark_no);
    int unsigned rises, cyc;
    logic        prev;
    rises = 1; prev = ir_out; cyc = 0;
    while (rises < mark_no && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (ir_out && !prev) rises++;
      prev = ir_out;
    end
    check("mark_seek", rises, mark_no);
  endtask

  task automatic reset_during(input logic [31:0] w, input int unsigned mark_no, input bit in_space);
    int unsigned cyc;
    send_word(w, 0);
    skip_to_mark(mark_no);
    if (in_space) begin
      cyc = 0;
      while (ir_out && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    @(posedge clk); #1;
    check("rst_pre_level", ir_out, !in_space);
    #3 readReset = 1'b1;
    #1;
    check("rst_ir", ir_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", send_ready, 1);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    readReset = 1'b0;
    exp_marks.delete();
    exp_frames.delete();
  endtask

  initial begin : stimulus
    int unsigned dones;
    readReset  = 1'b1;
    send_valid = 1'b0;
    send_data  = '0;
    abort      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ir", ir_out, 0);
    check("reset_ready", send_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    readReset = 1'b0;
    @(posedge clk); #1;

    // 16 ones and 16 zeros: 16*15 + 16*5 + 32*4 + 1 = 449 cycles
    send_word(32'hA5A5_0F0F, 0);
    wait_idle();

    // Second word offered while busy; it may only start after done
    send_word(32'h0000_0000, 1);
    send_word(32'hFFFF_FFFF, 0);
    wait_idle();

    // Abort wins over send_valid in IDLE
    abort      = 1'b1;
    send_valid = 1'b1;
    send_data  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_ready", send_ready, 1);
    send_valid = 1'b0;
    abort      = 1'b0;
    @(posedge clk); #1;

    // Abort on the third cycle of data bit 7's mark (the 25th mark)
    send_word(32'h1234_5678, 0);
    skip_to_mark(25);
    repeat (2) @(posedge clk);
    #1;
    check("abort_mark_high", ir_out, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ir", ir_out, 0);
    check("abort_ready", send_ready, 1);
    check("abort_busy", busy, 0);
    exp_marks.delete();
    exp_frames.delete();
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    reset_during(32'hA5A5_0F0F, 3, 0);
    reset_during(32'hA5A5_0F0F, 12, 1);
    send_word(32'hC3C3_3C3C, 0);
    wait_idle();

    for (int n = 0; n < 100; n++) begin
      send_word($urandom(), 0);
      wait_idle();
    end
    check("scoreboard_drained", exp_frames.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
